// File: rtl/ysyx_24100005_data_mem_responder.sv
// ysyx_24100005_data_mem_responder
//   Responder end of the LSU load/store interface. Word requests (read or
//   byte-masked write) are accepted on a valid/ready request channel, serviced
//   from an internal word array after LATENCY cycles, and answered on a
//   registered valid/ready response channel. One transaction is in flight
//   at a time.
//   Optional feature: define MEM_RESP_MISALIGN_CHK_EN to flag misaligned
//   accesses as errors. A write whose set mask lanes all sit at or above
//   addr[1:0] is still allowed. With the macro undefined, addr[1:0] is
//   ignored.
module ysyx_24100005_data_mem_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000,
  parameter int                LATENCY   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,        // asynchronous, active-low
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_wmask_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATENCY - 1);
  // One extra bit so 4*DEPTH never truncates against a narrow address.
  localparam logic [ADDR_W:0]   SPAN     = (ADDR_W + 1)'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wmask_q;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;

  logic               accept;
  logic               done;

  logic [31:0]        mem_q [DEPTH];

  // Address decode on the captured request.
  logic [ADDR_W-1:0]  off;
  logic [IDX_W-1:0]   idx;
  logic               in_range;
  logic               misalign_err;
  logic               acc_err;

  // Unsigned offset from the base: addresses below the base wrap to a huge
  // offset and fail the span test, so nothing aliases into the array.
  always_comb begin
    off      = addr_q - BASE_ADDR;
    idx      = off[IDX_W+1:2];
    in_range = ({1'b0, off} < SPAN);
  end

`ifdef MEM_RESP_MISALIGN_CHK_EN
  logic [3:0] below_mask;
  // Misaligned access is an error unless it is a write touching only lanes
  // at or above the byte offset (a narrow store inside the word).
  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    below_mask = 4'b0000;
      2'd1:    below_mask = 4'b0001;
      2'd2:    below_mask = 4'b0011;
      default: below_mask = 4'b0111;
    endcase
    misalign_err = (addr_q[1:0] != 2'd0) &&
                   !(we_q && ((wmask_q & below_mask) == 4'b0000));
  end
`else
  // Byte offset ignored: the access targets the containing word.
  always_comb misalign_err = 1'b0;
`endif

  always_comb acc_err = !in_range || misalign_err;

  // FSM state and latency counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (req_valid_i) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) state_d = RESP;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only when idle; done marks the WAIT->RESP edge.
  always_comb begin
    req_ready_o = (state_q == IDLE);
    accept      = (state_q == IDLE) && req_valid_i;
    done        = (state_q == WAIT) && (cnt_q == CNT_LAST);
  end

  // Capture the request at accept; held for the rest of the transaction.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      wmask_q <= req_wmask_i;
    end
  end

  // Array write: lane-masked commit on the WAIT->RESP edge. Gated by reset
  // so a write pending when reset hits is never committed.
  always_ff @(posedge clk_i) begin
    if (rst_i && done && we_q && !acc_err) begin
      for (int b = 0; b < 4; b++)
        if (wmask_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  // Response next-state: load on done, clear after handshake, else hold.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if (done) begin
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      resp_rdata_d = (!we_q && !acc_err) ? mem_q[idx] : 32'h0;
    end else if (resp_valid_q && resp_ready_i) begin
      resp_valid_d = 1'b0;
      resp_rdata_d = 32'h0;
      resp_err_d   = 1'b0;
    end
  end

  // Registered response channel.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

endmodule
